// File: rtl/dmem_pkg.sv
// Shared encodings for the RV32I data memory: funct3 access sizes, FSM states
// and the depth legality check.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic bit depth_ok(input int unsigned d);
        return (d >= 8) && (d % 4 == 0) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one 32-bit word: store byte-enables/replicated data,
// load lane select with sign/zero extension, and size/alignment legality.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rword[{off, 3'b000} +: 8];
    assign rhalf = off[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        be        = '0;
        wdata_sh  = wdata;
        rdata_ext = '0;
        misalign  = 1'b0;
        illegal   = 1'b0;
        case (funct3)
            F3_B: begin
                be        = 4'b0001 << off;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = {{24{rbyte[7]}}, rbyte};
            end
            F3_BU: begin
                rdata_ext = {24'b0, rbyte};
                illegal   = we;
            end
            F3_H: begin
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = {{16{rhalf[15]}}, rhalf};
                misalign  = off[0];
            end
            F3_HU: begin
                rdata_ext = {16'b0, rhalf};
                misalign  = off[0];
                illegal   = we;
            end
            F3_W: begin
                be        = 4'b1111;
                rdata_ext = rword;
                misalign  = |off;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// RV32I MEM-stage data memory: byte array, post-reset clear FSM, one-cycle
// registered response with fault reporting, and a side debug read port.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter  int unsigned DEPTH_BYTES = 64,
    localparam int unsigned IDX_W       = $clog2(DEPTH_BYTES)
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [2:0]       funct3_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic             ready_o,
    output logic             rvalid_o,
    output logic [31:0]      rdata_o,
    output logic             fault_o,
    input  logic [IDX_W-1:0] dbg_addr_i,
    output logic [31:0]      dbg_data_o
);

    localparam int unsigned WORDS = DEPTH_BYTES / 4;
    localparam int unsigned CNT_W = IDX_W - 2;

    if (!depth_ok(DEPTH_BYTES)) begin : g_bad_depth
        $error("DEPTH_BYTES must be a power of 2, a multiple of 4 and >= 8");
    end

    logic [7:0]       mem [DEPTH_BYTES];
    state_t           state_q, state_d;
    logic [CNT_W-1:0] clr_q, clr_d;

    logic [CNT_W-1:0] word_idx;
    logic [31:0]      rword, wdata_sh, rdata_ext;
    logic [3:0]       be;
    logic             misalign, illegal, range_err, fault, accept;

    assign word_idx = addr_i[IDX_W-1:2];
    assign rword    = {mem[{word_idx, 2'd3}], mem[{word_idx, 2'd2}],
                       mem[{word_idx, 2'd1}], mem[{word_idx, 2'd0}]};

    dmem_lane_align u_align (
        .funct3    (funct3_i),
        .we        (we_i),
        .off       (addr_i[1:0]),
        .wdata     (wdata_i),
        .rword     (rword),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext),
        .misalign  (misalign),
        .illegal   (illegal)
    );

    assign range_err = |addr_i[31:IDX_W];
    assign fault     = range_err | misalign | illegal;
    assign accept    = req_i & ready_o;

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        ready_o = 1'b0;
        case (state_q)
            ST_INIT: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == CNT_W'(WORDS - 1)) state_d = ST_RUN;
            end
            ST_RUN:  ready_o = 1'b1;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_INIT;
            clr_q    <= '0;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            fault_o  <= 1'b0;
        end else begin
            state_q  <= state_d;
            clr_q    <= clr_d;
            rvalid_o <= accept;
            if (accept) begin
                fault_o <= fault;
                rdata_o <= (we_i || fault) ? 32'h0 : rdata_ext;
            end
        end
    end

    // Array has no reset; the INIT sweep zeroes it one word per cycle instead.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_INIT) begin
            for (int i = 0; i < 4; i++) mem[{clr_q, 2'(i)}] <= 8'h00;
        end else if (accept && we_i && !fault) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[{word_idx, 2'(i)}] <= wdata_sh[8*i +: 8];
        end
    end

    logic [IDX_W-1:0] dbg_a1, dbg_a2, dbg_a3;
    assign dbg_a1     = dbg_addr_i + IDX_W'(1);
    assign dbg_a2     = dbg_addr_i + IDX_W'(2);
    assign dbg_a3     = dbg_addr_i + IDX_W'(3);
    assign dbg_data_o = {mem[dbg_a3], mem[dbg_a2], mem[dbg_a1], mem[dbg_addr_i]};

endmodule
